axi_sim_ram: RTL and testbench

- Behavioural AXI4 slave RAM with independent write (AW/W/B) and read (AR/R) channels.
- Serves as the DRAM model behind the prefetcher in block-level benches.
- Accepts INCR bursts of 1–256 beats and stores data in an internal word array.
- Write and read channels run fully concurrently.

---
 rtl/axi_sim_ram_pkg.sv | 26 ++
 rtl/axi_sim_ram_r_pipe.sv | 44 ++++
 rtl/axi_sim_ram.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi_sim_ram.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sim_ram_pkg.sv
// Shared constants and FSM state types for the axi_sim_ram behavioural AXI4 slave.
package axi_sim_ram_pkg;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;
  localparam logic [1:0] OKAY  = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_WRITE = 2'd1,
    W_RESP  = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } r_state_t;

  // Snapshot of both channel FSMs, kept as one signal so checkers can bind to it.
  typedef struct packed {
    w_state_t w_state;
    r_state_t r_state;
  } ram_dbg_t;

endpackage

// File: rtl/axi_sim_ram_r_pipe.sv
// Two-entry skid register for the R channel: one cycle of latency, full throughput,
// and an upstream ready that is a plain flop output.
module axi_sim_ram_r_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  // valid/ready: a beat moves when valid and ready are both high on a rising edge;
  // once valid is raised the payload holds until that edge.
  assign in_ready = !skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_ready || !out_valid) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && in_ready) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/axi_sim_ram.sv
// Behavioural AXI4 slave RAM with concurrent write (AW/W/B) and read (AR/R) channels.
// Define AXI_SIM_RAM_ZERO_INIT_EN to start the array at all zeros instead of X.
module axi_sim_ram
  import axi_sim_ram_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = 8,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int ADDR_LSB  = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH = ADDR_WIDTH - ADDR_LSB;
  localparam int WORDS     = 2 ** IDX_WIDTH;

`ifdef AXI_SIM_RAM_ZERO_INIT_EN
  logic [DATA_WIDTH-1:0] mem [WORDS] = '{default: '0};
`else
  logic [DATA_WIDTH-1:0] mem [WORDS];
`endif

  function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_WIDTH'(a >> ADDR_LSB);
  endfunction

  // WRAP bursts step like INCR; FIXED (and the reserved code) stay put.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    case (burst)
      FIXED:      return a;
      INCR, WRAP: return a + (ADDR_WIDTH'(1) << size);
      default:    return a;
    endcase
  endfunction

  // Holds the ready outputs low until the first clock after reset release.
  logic rst_done;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_done <= 1'b0;
    else     rst_done <= 1'b1;
  end

  // ---------------- write channel ----------------
  w_state_t              w_state, w_state_next;
  logic [ID_WIDTH-1:0]   wr_id;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_cnt;
  logic [2:0]            wr_size;
  logic [1:0]            wr_burst;
  logic                  aw_fire, w_fire, b_fire;

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid && s_axi_wready;
  assign b_fire  = s_axi_bvalid && s_axi_bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_next;
  end

  // The beat counter alone ends the burst; wlast is not consulted.
  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_state_next = W_WRITE;
      W_WRITE: if (w_fire && wr_cnt == 8'd0) w_state_next = W_RESP;
      W_RESP:  if (b_fire) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = (w_state == W_IDLE) && rst_done;
    s_axi_wready  = (w_state == W_WRITE);
    s_axi_bvalid  = (w_state == W_RESP);
    s_axi_bid     = wr_id;
    s_axi_bresp   = OKAY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_id    <= '0;
      wr_addr  <= '0;
      wr_cnt   <= '0;
      wr_size  <= '0;
      wr_burst <= '0;
    end else if (aw_fire) begin
      wr_id    <= s_axi_awid;
      wr_addr  <= s_axi_awaddr;
      wr_cnt   <= s_axi_awlen;
      wr_size  <= s_axi_awsize;
      wr_burst <= s_axi_awburst;
    end else if (w_fire) begin
      wr_addr <= next_addr(wr_addr, wr_size, wr_burst);
      wr_cnt  <= wr_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t              r_state, r_state_next;
  logic [ID_WIDTH-1:0]   rd_id;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_next;
  logic [7:0]            rd_cnt;
  logic [2:0]            rd_size;
  logic [1:0]            rd_burst;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  core_rvalid, core_rready, core_rlast;
  logic [ID_WIDTH-1:0]   core_rid;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  ar_fire, rc_fire, rc_last;

  assign ar_fire      = s_axi_arvalid && s_axi_arready;
  assign rc_fire      = core_rvalid && core_rready;
  assign rc_last      = (rd_cnt == 8'd0);
  assign rd_addr_next = next_addr(rd_addr, rd_size, rd_burst);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_state_next = R_READ;
      R_READ:  if (rc_fire && rc_last) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = (r_state == R_IDLE) && rst_done;
    core_rvalid   = (r_state == R_READ);
    core_rlast    = (r_state == R_READ) && rc_last;
    core_rid      = rd_id;
    core_rdata    = rd_data;
  end

  // rd_data is the registered array output; a write landing on the same edge is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_id    <= '0;
      rd_addr  <= '0;
      rd_cnt   <= '0;
      rd_size  <= '0;
      rd_burst <= '0;
      rd_data  <= '0;
    end else if (ar_fire) begin
      rd_id    <= s_axi_arid;
      rd_addr  <= s_axi_araddr;
      rd_cnt   <= s_axi_arlen;
      rd_size  <= s_axi_arsize;
      rd_burst <= s_axi_arburst;
      rd_data  <= mem[word_idx(s_axi_araddr)];
    end else if (rc_fire && !rc_last) begin
      rd_addr <= rd_addr_next;
      rd_cnt  <= rd_cnt - 8'd1;
      rd_data <= mem[word_idx(rd_addr_next)];
    end
  end

  generate
    if (PIPELINE_OUTPUT != 0) begin : g_pipe
      localparam int PW = ID_WIDTH + DATA_WIDTH + 1;
      logic [PW-1:0] pipe_out;
      axi_sim_ram_r_pipe #(.WIDTH(PW)) u_r_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (core_rvalid),
        .in_ready  (core_rready),
        .in_data   ({core_rid, core_rdata, core_rlast}),
        .out_valid (s_axi_rvalid),
        .out_ready (s_axi_rready),
        .out_data  (pipe_out)
      );
      assign {s_axi_rid, s_axi_rdata, s_axi_rlast} = pipe_out;
    end else begin : g_direct
      assign s_axi_rvalid = core_rvalid;
      assign core_rready  = s_axi_rready;
      assign s_axi_rid    = core_rid;
      assign s_axi_rdata  = core_rdata;
      assign s_axi_rlast  = core_rlast;
    end
  endgenerate

  assign s_axi_rresp = OKAY;

  ram_dbg_t dbg_state;
  assign dbg_state = '{w_state: w_state, r_state: r_state};

  logic unused_ok;
  assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_arlock,
                       s_axi_arcache, s_axi_arprot, s_axi_wlast, dbg_state};

endmodule

// File: tb/tb_axi_sim_ram.sv
// Bench for axi_sim_ram: instance 0 without and instance 1 with the R output pipeline,
// both 8-bit data / 16-bit address, checked against a byte-array model of the memory.
module tb_axi_sim_ram;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  awid [2], arid [2], bid [2], rid [2];
  logic [15:0] awaddr [2], araddr [2];
  logic [7:0]  awlen [2], arlen [2];
  logic [2:0]  awsize [2], arsize [2], awprot [2], arprot [2];
  logic [1:0]  awburst [2], arburst [2], bresp [2], rresp [2];
  logic [3:0]  awcache [2], arcache [2];
  logic        awlock [2], arlock [2];
  logic        awvalid [2], awready [2], wvalid [2], wready [2], wlast [2];
  logic        bvalid [2], bready [2], arvalid [2], arready [2];
  logic        rvalid [2], rready [2], rlast [2];
  logic [7:0]  wdata [2], rdata [2];
  logic [0:0]  wstrb [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_sim_ram #(
      .DATA_WIDTH(8), .ADDR_WIDTH(16), .ID_WIDTH(8), .PIPELINE_OUTPUT(g)
    ) dut (
      .clk(clk), .rst(rst),
      .s_axi_awid(awid[g]), .s_axi_awaddr(awaddr[g]), .s_axi_awlen(awlen[g]),
      .s_axi_awsize(awsize[g]), .s_axi_awburst(awburst[g]), .s_axi_awlock(awlock[g]),
      .s_axi_awcache(awcache[g]), .s_axi_awprot(awprot[g]),
      .s_axi_awvalid(awvalid[g]), .s_axi_awready(awready[g]),
      .s_axi_wdata(wdata[g]), .s_axi_wstrb(wstrb[g]), .s_axi_wlast(wlast[g]),
      .s_axi_wvalid(wvalid[g]), .s_axi_wready(wready[g]),
      .s_axi_bid(bid[g]), .s_axi_bresp(bresp[g]), .s_axi_bvalid(bvalid[g]), .s_axi_bready(bready[g]),
      .s_axi_arid(arid[g]), .s_axi_araddr(araddr[g]), .s_axi_arlen(arlen[g]),
      .s_axi_arsize(arsize[g]), .s_axi_arburst(arburst[g]), .s_axi_arlock(arlock[g]),
      .s_axi_arcache(arcache[g]), .s_axi_arprot(arprot[g]),
      .s_axi_arvalid(arvalid[g]), .s_axi_arready(arready[g]),
      .s_axi_rid(rid[g]), .s_axi_rdata(rdata[g]), .s_axi_rresp(rresp[g]), .s_axi_rlast(rlast[g]),
      .s_axi_rvalid(rvalid[g]), .s_axi_rready(rready[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] model_mem [2][65536];

  // Byte address of beat n: FIXED repeats the base, INCR/WRAP step by 2**size, modulo 64 KiB.
  function automatic int beat_addr(input logic [15:0] base, input int n,
                                   input logic [2:0] size, input logic [1:0] burst);
    int step;
    step = (burst == 2'b00) ? 0 : (1 << size);
    return (int'(base) + n * step) % 65536;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_aw(input int u, input logic [15:0] addr, input logic [7:0] len,
                         input logic [7:0] id, input logic [2:0] size, input logic [1:0] burst);
    int guard = 0;
    awaddr[u] = addr; awlen[u] = len; awid[u] = id; awsize[u] = size; awburst[u] = burst;
    awvalid[u] = 1'b1;
    while (!awready[u] && guard < 200) begin @(negedge clk); guard++; end
    n_cmp++;
    if (awready[u] !== 1'b1) begin
      n_err++; $display("FAIL aw_handshake u%0d: awready=%b required 1", u, awready[u]);
    end
    @(negedge clk);
    awvalid[u] = 1'b0;
  endtask

  // strb_mode: 0 all strobes set, 1 random strobes, 2 no strobes.
  task automatic write_burst(input int u, input logic [15:0] addr, input logic [7:0] len,
                             input logic [7:0] id, input logic [2:0] size, input logic [1:0] burst,
                             input bit seq_data, input int strb_mode, input bit full_rate);
    logic [7:0] d [256];
    logic       s [256];
    int  beat = 0, guard = 0;
    bit  go, done;
    for (int i = 0; i <= int'(len); i++) begin
      d[i] = seq_data ? 8'(i) : 8'($urandom);
      s[i] = (strb_mode == 0) ? 1'b1 : (strb_mode == 1) ? 1'($urandom) : 1'b0;
    end
    send_aw(u, addr, len, id, size, burst);
    while (beat <= int'(len) && guard < 3000) begin
      go = full_rate || ($urandom_range(0, 3) != 0);
      wvalid[u] = go; wdata[u] = d[beat]; wstrb[u] = s[beat]; wlast[u] = (beat == int'(len));
      if (go && wready[u]) begin
        if (s[beat]) model_mem[u][beat_addr(addr, beat, size, burst)] = d[beat];
        beat++;
      end
      @(negedge clk); guard++;
    end
    wvalid[u] = 1'b0; wlast[u] = 1'b0;
    n_cmp++;
    if (beat != int'(len) + 1 || wready[u] !== 1'b0) begin
      n_err++;
      $display("FAIL w_burst_end u%0d: beats=%0d wready=%b required beats=%0d wready=0",
               u, beat, wready[u], int'(len) + 1);
    end
    done = 1'b0; guard = 0;
    while (!done && guard < 200) begin
      go = full_rate || ($urandom_range(0, 1) == 1);
      bready[u] = go;
      if (bvalid[u] && go) begin
        done = 1'b1;
        n_cmp++;
        if (bid[u] !== id || bresp[u] !== 2'b00) begin
          n_err++;
          $display("FAIL b_resp u%0d: bid=%h bresp=%b required bid=%h bresp=00", u, bid[u], bresp[u], id);
        end
      end
      @(negedge clk); guard++;
    end
    bready[u] = 1'b0;
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL b_timeout u%0d: bvalid=%b required 1", u, bvalid[u]); end
  endtask

  // rmode: 0 random rready, 1 rready held high, 2 rready pattern 1,0,0,1 per valid cycle.
  // exp_lat > 0 checks the edges from AR handshake to the first visible rvalid.
  task automatic read_burst(input int u, input logic [15:0] addr, input logic [7:0] len,
                            input logic [7:0] id, input logic [2:0] size, input logic [1:0] burst,
                            input int rmode, input int exp_lat);
    logic [7:0] exp_q [$];
    int  guard = 0, lat, k = 0, cyc = 0, n = 0;
    bit  go;
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(model_mem[u][beat_addr(addr, i, size, burst)]);
    araddr[u] = addr; arlen[u] = len; arid[u] = id; arsize[u] = size; arburst[u] = burst;
    arvalid[u] = 1'b1;
    while (!arready[u] && guard < 200) begin @(negedge clk); guard++; end
    n_cmp++;
    if (arready[u] !== 1'b1) begin
      n_err++; $display("FAIL ar_handshake u%0d: arready=%b required 1", u, arready[u]);
    end
    @(negedge clk);
    arvalid[u] = 1'b0;
    lat = 1;
    while (!rvalid[u] && lat < 50) begin @(negedge clk); lat++; end
    if (exp_lat > 0) begin
      n_cmp++;
      if (lat != exp_lat) begin
        n_err++; $display("FAIL r_latency u%0d: latency=%0d required %0d", u, lat, exp_lat);
      end
    end
    while (exp_q.size() > 0 && cyc < 3000) begin
      case (rmode)
        0:       go = ($urandom_range(0, 1) == 1);
        1:       go = 1'b1;
        default: go = (k % 4 == 0) || (k % 4 == 3);
      endcase
      rready[u] = go;
      if (rvalid[u]) begin
        n_cmp++;
        if (rdata[u] !== exp_q[0] || rid[u] !== id || rresp[u] !== 2'b00 ||
            rlast[u] !== (exp_q.size() == 1)) begin
          n_err++;
          $display("FAIL r_beat u%0d beat %0d: rdata=%h rid=%h rresp=%b rlast=%b required rdata=%h rid=%h rresp=00 rlast=%b",
                   u, n, rdata[u], rid[u], rresp[u], rlast[u], exp_q[0], id, exp_q.size() == 1);
        end
        if (go) begin void'(exp_q.pop_front()); n++; end
        k++;
      end
      @(negedge clk); cyc++;
    end
    rready[u] = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0 || rvalid[u] !== 1'b0 || arready[u] !== 1'b1) begin
      n_err++;
      $display("FAIL r_burst_end u%0d: beats_left=%0d rvalid=%b arready=%b required 0/0/1",
               u, exp_q.size(), rvalid[u], arready[u]);
    end
    if (rmode == 1) begin
      n_cmp++;
      if (cyc != int'(len) + 1) begin
        n_err++; $display("FAIL r_throughput u%0d: cycles=%0d required %0d", u, cyc, int'(len) + 1);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      if ({awready[u], wready[u], bvalid[u], arready[u], rvalid[u], rlast[u]} !== 6'b0 ||
          bid[u] !== 8'h00 || rid[u] !== 8'h00 || rdata[u] !== 8'h00 ||
          bresp[u] !== 2'b00 || rresp[u] !== 2'b00) begin
        n_err++;
        $display("FAIL reset_outputs u%0d: aw/w/b/ar/r/last=%b%b%b%b%b%b bid=%h rid=%h rdata=%h bresp=%b rresp=%b required all zero",
                 u, awready[u], wready[u], bvalid[u], arready[u], rvalid[u], rlast[u],
                 bid[u], rid[u], rdata[u], bresp[u], rresp[u]);
      end
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      if (awready[u] !== 1'b1 || arready[u] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_release u%0d: awready=%b arready=%b required 1/1", u, awready[u], arready[u]);
      end
    end
  endtask

  task automatic test_write_burst();
    write_burst(0, 16'h0EEF, 8'd99, 8'd5, 3'd0, 2'b01, 1'b1, 0, 1'b0);
  endtask

  task automatic test_single_reads();
    read_burst(0, 16'h0EEF, 8'd0, 8'd5, 3'd0, 2'b01, 1, 1);
    read_burst(0, 16'h0EF2, 8'd0, 8'd5, 3'd0, 2'b01, 1, 1);
    read_burst(0, 16'h0EF5, 8'd0, 8'd5, 3'd0, 2'b01, 1, 1);
  endtask

  task automatic test_back_to_back();
    read_burst(0, 16'h0EEF, 8'd3, 8'd5, 3'd0, 2'b01, 2, 1);
    read_burst(0, 16'h0EEF, 8'd99, 8'd7, 3'd0, 2'b01, 1, 1);
  endtask

  task automatic test_zero_strobe();
    write_burst(0, 16'h0EF0, 8'd0, 8'd6, 3'd0, 2'b01, 1'b0, 2, 1'b1);
    read_burst(0, 16'h0EF0, 8'd0, 8'd6, 3'd0, 2'b01, 1, 1);
  endtask

  task automatic test_reset_mid_burst();
    int guard = 0;
    araddr[0] = 16'h0EEF; arlen[0] = 8'd3; arid[0] = 8'h33; arsize[0] = 3'd0; arburst[0] = 2'b01;
    arvalid[0] = 1'b1;
    while (!arready[0] && guard < 200) begin @(negedge clk); guard++; end
    @(negedge clk);
    arvalid[0] = 1'b0;
    rready[0] = 1'b1;
    @(negedge clk);
    rready[0] = 1'b0;
    n_cmp++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== model_mem[0][16'h0EF0]) begin
      n_err++;
      $display("FAIL rst_pre_beat: rvalid=%b rdata=%h required 1/%h", rvalid[0], rdata[0], model_mem[0][16'h0EF0]);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rvalid[0] !== 1'b0 || rlast[0] !== 1'b0 || rid[0] !== 8'h00 || rdata[0] !== 8'h00 ||
        arready[0] !== 1'b0 || awready[0] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_burst: rvalid=%b rlast=%b rid=%h rdata=%h arready=%b awready=%b required all zero",
               rvalid[0], rlast[0], rid[0], rdata[0], arready[0], awready[0]);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (arready[0] !== 1'b1 || rvalid[0] !== 1'b0 || bvalid[0] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_recover: arready=%b rvalid=%b bvalid=%b required 1/0/0", arready[0], rvalid[0], bvalid[0]);
    end
    read_burst(0, 16'h0EEF, 8'd3, 8'd8, 3'd0, 2'b01, 0, 1);
  endtask

  task automatic test_address_wrap();
    write_burst(0, 16'hFFFE, 8'd3, 8'h21, 3'd0, 2'b01, 1'b0, 0, 1'b0);
    read_burst(0, 16'hFFFE, 8'd3, 8'h22, 3'd0, 2'b01, 0, 1);
    read_burst(0, 16'h0001, 8'd0, 8'h23, 3'd0, 2'b01, 1, 1);
  endtask

  task automatic test_random_bursts(input int u, input int iters);
    logic [15:0] addr;
    logic [7:0]  len, id;
    logic [2:0]  size;
    logic [1:0]  burst;
    for (int t = 0; t < iters; t++) begin
      addr  = 16'($urandom);
      len   = 8'($urandom_range(0, 15));
      size  = 3'($urandom_range(0, 2));
      burst = 2'($urandom_range(0, 2));
      id    = 8'($urandom);
      write_burst(u, addr, len, id, size, burst, 1'b0, 0, 1'b0);
      write_burst(u, addr, len, id + 8'd1, size, burst, 1'b0, 1, 1'b0);
      read_burst(u, addr, len, id + 8'd2, size, burst, 0, (u == 1) ? 2 : 1);
    end
  endtask

  task automatic test_pipeline();
    write_burst(1, 16'h0EEF, 8'd99, 8'd5, 3'd0, 2'b01, 1'b1, 0, 1'b0);
    read_burst(1, 16'h0EEF, 8'd0, 8'd5, 3'd0, 2'b01, 1, 2);
    read_burst(1, 16'h0EEF, 8'd3, 8'd5, 3'd0, 2'b01, 2, 2);
    read_burst(1, 16'h0EEF, 8'd99, 8'd5, 3'd0, 2'b01, 1, 2);
    read_burst(1, 16'h0EEF, 8'd99, 8'd9, 3'd0, 2'b01, 0, 2);
    test_random_bursts(1, 4);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      awid[u] = '0; awaddr[u] = '0; awlen[u] = '0; awsize[u] = '0; awburst[u] = '0;
      awlock[u] = 1'b0; awcache[u] = '0; awprot[u] = '0; awvalid[u] = 1'b0;
      wdata[u] = '0; wstrb[u] = '0; wlast[u] = 1'b0; wvalid[u] = 1'b0; bready[u] = 1'b0;
      arid[u] = '0; araddr[u] = '0; arlen[u] = '0; arsize[u] = '0; arburst[u] = '0;
      arlock[u] = 1'b0; arcache[u] = '0; arprot[u] = '0; arvalid[u] = 1'b0; rready[u] = 1'b0;
    end
    test_reset();
    test_write_burst();
    test_single_reads();
    test_back_to_back();
    test_zero_strobe();
    test_reset_mid_burst();
    test_address_wrap();
    test_random_bursts(0, 6);
    test_pipeline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
